// File: rtl/fft16_frame_ctrl_if.sv
// Handshake and status bundle for the 16-point FFT frame controller.
// The master side drives input beats and abort; the slave side is the controller.
interface fft16_frame_ctrl_if;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic       stage1_en;
  logic [1:0] mux_1_out;
  logic       out_valid;
  logic [1:0] mux_2_out;
  logic       out_last;
  logic       busy;
  logic [7:0] frame_cnt;
  logic       err_drop;

  modport master (
    output abort, in_valid,
    input  in_ready, stage1_en, mux_1_out,
    input  out_valid, mux_2_out, out_last,
    input  busy, frame_cnt, err_drop
  );

  modport slave (
    input  abort, in_valid,
    output in_ready, stage1_en, mux_1_out,
    output out_valid, mux_2_out, out_last,
    output busy, frame_cnt, err_drop
  );
endinterface

// File: rtl/fft16_frame_ctrl.sv
// Frame sequencer for a radix-4 16-point FFT: loads 4 input beats,
// waits PIPE_LAT cycles for the pipeline to drain, then emits 4 output beats.
module fft16_frame_ctrl #(
  parameter int unsigned PIPE_LAT = 3
) (
  input logic               clk,
  input logic               reset,
  fft16_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    OUT
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] beat;
  logic [1:0] beat_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;
  logic       accept;
  logic       frame_done;
  logic       s1en_q;
  logic [1:0] mux1_q;
  logic [7:0] fcnt_q;
  logic       err_q;

  assign bus.in_ready = (state == IDLE) || (state == LOAD);
  assign accept = bus.in_valid && bus.in_ready && !bus.abort;
  // an abort in the final output cycle cancels the count
  assign frame_done = (state == OUT) && (beat == 2'd3) && !bus.abort;

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    wait_nxt  = wait_cnt;
    unique case (state)
      IDLE, LOAD: begin
        if (accept) begin
          if (beat == 2'd3) begin
            state_nxt = DRAIN;
            beat_nxt  = 2'd0;
            wait_nxt  = 4'(PIPE_LAT);
          end else begin
            state_nxt = LOAD;
            beat_nxt  = beat + 2'd1;
          end
        end
      end
      DRAIN: begin
        if (wait_cnt <= 4'd1) begin
          state_nxt = OUT;
          wait_nxt  = 4'd0;
        end else begin
          wait_nxt = wait_cnt - 4'd1;
        end
      end
      OUT: begin
        beat_nxt = beat + 2'd1;
        if (beat == 2'd3) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = 2'd0;
        wait_nxt  = 4'd0;
      end
    endcase
    if (bus.abort) begin
      state_nxt = IDLE;
      beat_nxt  = 2'd0;
      wait_nxt  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat     <= 2'd0;
      wait_cnt <= 4'd0;
      s1en_q   <= 1'b0;
      mux1_q   <= 2'd0;
      fcnt_q   <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      wait_cnt <= wait_nxt;
      s1en_q   <= accept;
      if (accept) begin
        mux1_q <= beat;
      end
      if (frame_done) begin
        fcnt_q <= fcnt_q + 8'd1;
      end
      err_q <= bus.in_valid && !bus.in_ready;
    end
  end

  assign bus.stage1_en = s1en_q;
  assign bus.mux_1_out = mux1_q;
  assign bus.out_valid = (state == OUT);
  assign bus.mux_2_out = (state == OUT) ? beat : 2'd0;
  assign bus.out_last  = (state == OUT) && (beat == 2'd3);
  assign bus.busy      = (state != IDLE);
  assign bus.frame_cnt = fcnt_q;
  assign bus.err_drop  = err_q;

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Bench for fft16_frame_ctrl: three instances (PIPE_LAT 3, 1, 15) share one
// stimulus stream and are checked against a timestamp-based frame model.
module tb_fft16_frame_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic iv = 1'b0;
  logic ab = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   t = 0;

  int unsigned lat [3] = '{3, 1, 15};

  fft16_frame_ctrl_if i3 ();
  fft16_frame_ctrl_if i1 ();
  fft16_frame_ctrl_if i15 ();

  assign i3.in_valid  = iv;
  assign i3.abort     = ab;
  assign i1.in_valid  = iv;
  assign i1.abort     = ab;
  assign i15.in_valid = iv;
  assign i15.abort    = ab;

  fft16_frame_ctrl #(.PIPE_LAT(3))  u3  (.clk(clk), .reset(reset), .bus(i3));
  fft16_frame_ctrl #(.PIPE_LAT(1))  u1  (.clk(clk), .reset(reset), .bus(i1));
  fft16_frame_ctrl #(.PIPE_LAT(15)) u15 (.clk(clk), .reset(reset), .bus(i15));

  always #5 clk = ~clk;

  // model state: beats taken, edge at which output starts (-1 = none)
  int         m_beats [3];
  int         m_start [3] = '{-1, -1, -1};
  bit         m_rdy   [3] = '{1'b1, 1'b1, 1'b1};
  bit         m_s1en  [3];
  bit   [1:0] m_mux1  [3];
  bit   [7:0] m_fc    [3];
  bit         m_err   [3];
  logic [17:0] exp_vec [3];

  always @(posedge clk) begin
    bit acc;
    bit ov;
    bit [1:0] mux2;
    t = t + 1;
    for (int i = 0; i < 3; i++) begin
      acc = 1'b0;
      if (reset) begin
        m_beats[i] = 0;
        m_start[i] = -1;
        m_s1en[i]  = 1'b0;
        m_mux1[i]  = 2'd0;
        m_fc[i]    = 8'd0;
        m_err[i]   = 1'b0;
      end else begin
        m_err[i] = iv && !m_rdy[i];
        acc = iv && m_rdy[i] && !ab;
        if (ab) begin
          m_beats[i] = 0;
          m_start[i] = -1;
        end else begin
          if (m_start[i] >= 0 && t == m_start[i] + 4) begin
            m_fc[i] = m_fc[i] + 8'd1;
            m_start[i] = -1;
          end
          if (acc) begin
            m_mux1[i] = 2'(m_beats[i]);
            if (m_beats[i] == 3) begin
              m_beats[i] = 0;
              m_start[i] = t + int'(lat[i]);
            end else begin
              m_beats[i] = m_beats[i] + 1;
            end
          end
        end
        m_s1en[i] = acc;
      end
      m_rdy[i] = (m_start[i] < 0);
      ov = (m_start[i] >= 0) && (t >= m_start[i]) && (t < m_start[i] + 4);
      mux2 = ov ? 2'(t - m_start[i]) : 2'd0;
      exp_vec[i] = {m_rdy[i], m_s1en[i], m_mux1[i], ov, mux2,
                    ov && (mux2 == 2'd3),
                    (m_beats[i] > 0) || (m_start[i] >= 0),
                    m_fc[i], m_err[i]};
    end
  end

  function automatic logic [17:0] obs_vec(input int i);
    case (i)
      0: obs_vec = {i3.in_ready, i3.stage1_en, i3.mux_1_out, i3.out_valid,
                    i3.mux_2_out, i3.out_last, i3.busy, i3.frame_cnt,
                    i3.err_drop};
      1: obs_vec = {i1.in_ready, i1.stage1_en, i1.mux_1_out, i1.out_valid,
                    i1.mux_2_out, i1.out_last, i1.busy, i1.frame_cnt,
                    i1.err_drop};
      default: obs_vec = {i15.in_ready, i15.stage1_en, i15.mux_1_out,
                          i15.out_valid, i15.mux_2_out, i15.out_last,
                          i15.busy, i15.frame_cnt, i15.err_drop};
    endcase
  endfunction

  task automatic cyc(input logic v, input logic a, input logic r);
    iv = v;
    ab = a;
    reset = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_vec(i) !== 18'h20000) begin
        bad++;
        $display("FAIL reset dut%0d got=%h want=%h", i, obs_vec(i), 18'h20000);
      end
      total++;
      if (obs_vec(i) !== exp_vec[i]) begin
        bad++;
        $display("FAIL reset_model dut%0d got=%h want=%h",
                 i, obs_vec(i), exp_vec[i]);
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    int first [3];
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      total++;
      if (i3.stage1_en !== 1'b1 || i3.mux_1_out !== 2'(k)) begin
        bad++;
        $display("FAIL basic_s1 beat%0d got=%b/%0d want=1/%0d",
                 k, i3.stage1_en, i3.mux_1_out, k);
      end
    end
    first = '{-1, -1, -1};
    for (int n = 1; n <= 24; n++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (first[0] < 0 && i3.out_valid === 1'b1) first[0] = n;
      if (first[1] < 0 && i1.out_valid === 1'b1) first[1] = n;
      if (first[2] < 0 && i15.out_valid === 1'b1) first[2] = n;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec[i]) begin
          bad++;
          $display("FAIL basic dut%0d n=%0d got=%h want=%h",
                   i, n, obs_vec(i), exp_vec[i]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (first[i] != int'(lat[i])) begin
        bad++;
        $display("FAIL latency dut%0d got=%0d want=%0d", i, first[i], lat[i]);
      end
    end
    total++;
    if (i3.frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL basic_fc got=%0d want=1", i3.frame_cnt);
    end
  endtask

  task automatic test_gapped();
    logic [9:0] pat;
    pat = 10'b1000011001;
    for (int n = 0; n < 30; n++) begin
      cyc((n < 10) ? pat[n] : 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec[i]) begin
          bad++;
          $display("FAIL gapped dut%0d n=%0d got=%h want=%h",
                   i, n, obs_vec(i), exp_vec[i]);
        end
      end
      if (n >= 9 && n <= 15) begin
        total++;
        if (i3.out_valid !== (n >= 12)) begin
          bad++;
          $display("FAIL gapped_ov n=%0d got=%b want=%b",
                   n, i3.out_valid, n >= 12);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int errs;
    errs = 0;
    for (int n = 0; n < 30; n++) begin
      cyc(n < 12, 1'b0, 1'b0);
      if (i3.err_drop === 1'b1) errs++;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec[i]) begin
          bad++;
          $display("FAIL overrun dut%0d n=%0d got=%h want=%h",
                   i, n, obs_vec(i), exp_vec[i]);
        end
      end
    end
    total++;
    if (errs != 7) begin
      bad++;
      $display("FAIL overrun_err got=%0d want=7", errs);
    end
  endtask

  task automatic test_abort();
    logic [7:0] fc;
    int guard;
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    fc = i3.frame_cnt;
    cyc(1'b0, 1'b1, 1'b0);
    total++;
    if (i3.busy !== 1'b0 || i3.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_drain got=%b%b want=00", i3.busy, i3.out_valid);
    end
    repeat (8) begin
      cyc(1'b0, 1'b0, 1'b0);
      total++;
      if (i3.out_valid !== 1'b0 || i3.frame_cnt !== fc) begin
        bad++;
        $display("FAIL abort_quiet got=%b/%0d want=0/%0d",
                 i3.out_valid, i3.frame_cnt, fc);
      end
    end
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (i3.out_last !== 1'b1 && guard < 40) begin
      cyc(1'b0, 1'b0, 1'b0);
      guard++;
    end
    total++;
    if (guard >= 40) begin
      bad++;
      $display("FAIL abort_wait got=timeout want=out_last");
    end
    fc = i3.frame_cnt;
    cyc(1'b0, 1'b1, 1'b0);
    total++;
    if (i3.frame_cnt !== fc || i3.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_last got=%0d/%b want=%0d/0",
               i3.frame_cnt, i3.out_valid, fc);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_vec(i) !== exp_vec[i]) begin
        bad++;
        $display("FAIL abort dut%0d got=%h want=%h",
                 i, obs_vec(i), exp_vec[i]);
      end
    end
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_vec(i) !== 18'h20000) begin
        bad++;
        $display("FAIL rst_abort dut%0d got=%h want=%h",
                 i, obs_vec(i), 18'h20000);
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom % 10) < 7, ($urandom % 40) == 0, ($urandom % 200) == 0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec[i]) begin
          bad++;
          $display("FAIL random dut%0d n=%0d got=%h want=%h",
                   i, n, obs_vec(i), exp_vec[i]);
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] fc;
    int lasts;
    int guard;
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    fc = i3.frame_cnt;
    lasts = 0;
    guard = 0;
    while (lasts < 256 && guard < 4000) begin
      cyc(1'b1, 1'b0, 1'b0);
      guard++;
      if (i3.out_last === 1'b1) lasts++;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec[i]) begin
          bad++;
          $display("FAIL wrap dut%0d n=%0d got=%h want=%h",
                   i, guard, obs_vec(i), exp_vec[i]);
        end
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
    total++;
    if (lasts != 256 || i3.frame_cnt !== fc) begin
      bad++;
      $display("FAIL wrap_fc got=%0d/%0d want=256/%0d",
               lasts, i3.frame_cnt, fc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_abort();
    test_random();
    test_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
